// File: rtl/awg_dma_ingest.sv
// awg_dma_ingest: packs DMA words into sample batches, routes each batch to its
// channel buffer/address, checks tlast framing and reports one status per transfer.
module awg_dma_ingest #(
    parameter int unsigned DEPTH        = 1024,
    parameter int unsigned CHANNELS     = 8,
    parameter int unsigned AXI_MM_WIDTH = 128,
    parameter int unsigned DATA_WIDTH   = 256,
    localparam int unsigned AW          = $clog2(DEPTH)
) (
    input  logic                       dma_clk,
    input  logic                       dma_reset_n,

    input  logic [AXI_MM_WIDTH-1:0]    dma_data_data,
    input  logic                       dma_data_valid,
    input  logic                       dma_data_last,
    output logic                       dma_data_ready,

    input  logic [AW*CHANNELS-1:0]     write_depth_data,
    input  logic                       write_depth_valid,
    output logic                       write_depth_ready,

    output logic [1:0]                 xfer_err_data,
    output logic                       xfer_err_valid,
    input  logic                       xfer_err_ready,

    output logic [CHANNELS-1:0]        buf_wr_en,
    output logic [AW-1:0]              buf_wr_addr,
    output logic [DATA_WIDTH-1:0]      buf_wr_data,
    output logic                       buf_done
);

    // DMA words per batch, and counter widths (kept >= 1 bit for degenerate sizes)
    localparam int unsigned R  = DATA_WIDTH / AXI_MM_WIDTH;
    localparam int unsigned SW = (R > 1) ? $clog2(R) : 1;
    localparam int unsigned CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    // Transfer status codes
    localparam logic [1:0] CODE_OK      = 2'd0;
    localparam logic [1:0] CODE_NO_LAST = 2'd1;
    localparam logic [1:0] CODE_EARLY   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECV   = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

    state_t                  state;
    logic [CW-1:0]           ch;
    logic [AW-1:0]           addr;
    logic [SW-1:0]           subword;
    logic [AW-1:0]           depth [CHANNELS];
    logic [DATA_WIDTH-1:0]   batch;

    logic                    word_hs_c;
    logic                    batch_end_c;
    logic                    chan_end_c;
    logic                    final_c;
    logic [DATA_WIDTH-1:0]   batch_c;

    // Decode the word presented this cycle: handshake, batch/channel/transfer boundaries
    always_comb begin
        word_hs_c   = dma_data_valid && dma_data_ready;
        batch_end_c = (subword == SW'(R - 1));
        chan_end_c  = (addr == depth[ch]);
        final_c     = batch_end_c && chan_end_c && (ch == CW'(CHANNELS - 1));
    end

    // Merge the incoming word into its batch slot; the first word of a batch lands in the LSBs
    always_comb begin
        batch_c = batch;
        for (int k = 0; k < int'(R); k++) begin
            if (subword == SW'(k)) begin
                batch_c[k*AXI_MM_WIDTH +: AXI_MM_WIDTH] = dma_data_data;
            end
        end
    end

    // Transfer FSM with registered handshakes, buffer write port and status
    always_ff @(posedge dma_clk or negedge dma_reset_n) begin
        if (!dma_reset_n) begin
            state             <= ST_IDLE;
            ch                <= '0;
            addr              <= '0;
            subword           <= '0;
            batch             <= '0;
            for (int c = 0; c < int'(CHANNELS); c++) begin
                depth[c] <= '0;
            end
            dma_data_ready    <= 1'b0;
            write_depth_ready <= 1'b1;
            xfer_err_data     <= CODE_OK;
            xfer_err_valid    <= 1'b0;
            buf_wr_en         <= '0;
            buf_wr_addr       <= '0;
            buf_wr_data       <= '0;
            buf_done          <= 1'b0;
        end else begin
            buf_wr_en <= '0;
            buf_done  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (write_depth_valid && write_depth_ready) begin
                        for (int c = 0; c < int'(CHANNELS); c++) begin
                            depth[c] <= write_depth_data[c*AW +: AW];
                        end
                        ch                <= '0;
                        addr              <= '0;
                        subword           <= '0;
                        write_depth_ready <= 1'b0;
                        dma_data_ready    <= 1'b1;
                        state             <= ST_RECV;
                    end
                end

                ST_RECV: begin
                    if (word_hs_c) begin
                        batch <= batch_c;

                        // A completed batch is always written, even on an early tlast
                        if (batch_end_c) begin
                            buf_wr_en   <= CHANNELS'(1) << ch;
                            buf_wr_addr <= addr;
                            buf_wr_data <= batch_c;
                            subword     <= '0;
                            if (chan_end_c) begin
                                ch   <= ch + CW'(1);
                                addr <= '0;
                            end else begin
                                addr <= addr + AW'(1);
                            end
                        end else begin
                            subword <= subword + SW'(1);
                        end

                        // Either the planned final word or any tlast ends the transfer
                        if (final_c || dma_data_last) begin
                            dma_data_ready <= 1'b0;
                            xfer_err_valid <= 1'b1;
                            buf_done       <= final_c && dma_data_last;
                            state          <= ST_REPORT;
                            if (!final_c) begin
                                xfer_err_data <= CODE_EARLY;
                            end else if (dma_data_last) begin
                                xfer_err_data <= CODE_OK;
                            end else begin
                                xfer_err_data <= CODE_NO_LAST;
                            end
                        end
                    end
                end

                ST_REPORT: begin
                    if (xfer_err_ready) begin
                        xfer_err_valid    <= 1'b0;
                        write_depth_ready <= 1'b1;
                        state             <= ST_IDLE;
                    end
                end

                default: begin
                    dma_data_ready    <= 1'b0;
                    write_depth_ready <= 1'b1;
                    xfer_err_valid    <= 1'b0;
                    state             <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
